// File: rtl/alu_seq.sv
// Registered signed ALU with valid/ready handshakes and an iterative restoring divider for div/mod.
// Defining ALU_SEQ_FLAGS_EN adds registered zero/negative/carry/overflow status outputs.
module alu_seq #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic [3:0]          sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out,
  output logic                err
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_c,
  output logic                flag_v
`endif
);
  localparam int SW = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  out_q, out_d;
  logic          err_q, err_d;
  logic [N-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, a_q, a_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          negq_q, negq_d, negr_q, negr_d, bz_q, bz_d, mod_q, mod_d;

  logic          accept, ld_alu, ld_div, ge;
  logic [SW-1:0] amt;
  logic [N-1:0]  ua, ub, alu_res, quo_nx, rem_nx, div_res;
  logic [N:0]    rem_sh;

  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction

  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign err       = err_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    ua      = a;
    ub      = b;
    amt     = b[SW-1:0];
    alu_res = '0;
    case (sel)
      4'h0: alu_res = ua + ub;
      4'h1: alu_res = ua - ub;
      4'h2: alu_res = ua * ub;
      4'h5: alu_res = ua & ub;
      4'h6: alu_res = ua | ub;
      4'h7: alu_res = ~ua;
      4'h8: alu_res = ~(ua & ub);
      4'h9: alu_res = ~(ua | ub);
      4'hA: alu_res = ua ^ ub;
      4'hB: alu_res = ~(ua ^ ub);
      4'hC: alu_res = ua << amt;
      4'hD: alu_res = ua >> amt;
      4'hE: alu_res = (ua << amt) | (ua >> (N - amt));
      4'hF: alu_res = (ua >> amt) | (ua << (N - amt));
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    bz_d    = bz_q;
    mod_d   = mod_q;
    a_d     = a_q;
    ld_alu  = 1'b0;
    ld_div  = 1'b0;

    // One restoring step: shift the next dividend bit into the partial remainder.
    rem_sh  = {rem_q, quo_q[N-1]};
    ge      = rem_sh >= {1'b0, dvs_q};
    quo_nx  = {quo_q[N-2:0], ge};
    rem_nx  = ge ? (rem_sh[N-1:0] - dvs_q) : rem_sh[N-1:0];
    div_res = bz_q ? (mod_q ? a_q : '1)
                   : (mod_q ? (negr_q ? -rem_nx : rem_nx) : (negq_q ? -quo_nx : quo_nx));

    case (state_q)
      CALC: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(N - 1)) begin
          ld_div  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: ;
    endcase

    if (accept) begin
      if (sel == 4'h3 || sel == 4'h4) begin
        state_d = CALC;
        quo_d   = mag(a);
        dvs_d   = mag(b);
        rem_d   = '0;
        cnt_d   = '0;
        negq_d  = a[N-1] ^ b[N-1];
        negr_d  = a[N-1];
        bz_d    = (b == '0);
        mod_d   = sel[2];
        a_d     = a;
      end else begin
        ld_alu  = 1'b1;
        state_d = DONE;
      end
    end

    if (ld_alu) begin
      out_d = alu_res;
      err_d = 1'b0;
    end else if (ld_div) begin
      out_d = div_res;
      err_d = bz_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      err_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bz_q    <= 1'b0;
      mod_q   <= 1'b0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      bz_q    <= bz_d;
      mod_q   <= mod_d;
      a_q     <= a_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic                  fl_c, fl_v;
  logic                  fz_q, fn_q, fc_q, fv_q;
  logic [SW-1:0]         idx_l, idx_r;
  logic signed [2*N-1:0] prod;

  always_comb begin
    fl_c  = 1'b0;
    fl_v  = 1'b0;
    idx_l = -amt;
    idx_r = amt - 1'b1;
    prod  = $signed((2*N)'(a)) * $signed((2*N)'(b));
    case (sel)
      4'h0: begin
        fl_c = (a[N-1] & b[N-1]) | ((a[N-1] | b[N-1]) & ~alu_res[N-1]);
        fl_v = (a[N-1] == b[N-1]) && (alu_res[N-1] != a[N-1]);
      end
      4'h1: begin
        fl_c = ua < ub;
        fl_v = (a[N-1] != b[N-1]) && (alu_res[N-1] != a[N-1]);
      end
      4'h2: fl_v = prod != {{N{prod[N-1]}}, prod[N-1:0]};
      4'hC: fl_c = (amt != '0) && ua[idx_l];
      4'hD: fl_c = (amt != '0) && ua[idx_r];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      fc_q <= 1'b0;
      fv_q <= 1'b0;
    end else if (ld_alu || ld_div) begin
      fz_q <= (out_d == '0);
      fn_q <= out_d[N-1];
      fc_q <= ld_alu && fl_c;
      fv_q <= ld_alu && fl_v;
    end
  end

  assign flag_z = fz_q;
  assign flag_n = fn_q;
  assign flag_c = fc_q;
  assign flag_v = fv_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (N=8): directed cases, backpressure, reset abort, then random traffic.
module tb_alu_seq;
  logic              clk, rst_n, in_valid, in_ready, out_valid, out_ready, err;
  logic signed [7:0] a, b, out;
  logic [3:0]        sel;
`ifdef ALU_SEQ_FLAGS_EN
  logic              flag_z, flag_n, flag_c, flag_v;
`endif

  alu_seq #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .err(err)
`ifdef ALU_SEQ_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
`endif
  );

  typedef struct {
    logic [7:0] r;
    logic       e;
    logic [3:0] fl;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0, n_fail = 0, cyc = 0;
  logic       rdy_rand = 0, rdy_fixed = 1, seen = 0;
  logic [8:0] held;
  logic [3:0] cur_op;
  logic [7:0] cur_a, cur_b;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the signed operand values.
  task automatic model(input int op, input int sa, input int sb,
                       output logic [7:0] r, output logic e, output logic [3:0] fl);
    int ua, ub, amt, res, c, v;
    ua = sa & 255; ub = sb & 255; amt = sb & 7; res = 0; c = 0; v = 0; e = 0;
    case (op)
      0: begin res = sa + sb; c = ((ua + ub) > 255); v = (res > 127 || res < -128); end
      1: begin res = sa - sb; c = (ua < ub); v = (res > 127 || res < -128); end
      2: begin res = sa * sb; v = (res > 127 || res < -128); end
      3: if (sb == 0) begin res = -1; e = 1; end else res = sa / sb;
      4: if (sb == 0) begin res = sa; e = 1; end else res = sa % sb;
      5: res = ua & ub;
      6: res = ua | ub;
      7: res = ~ua;
      8: res = ~(ua & ub);
      9: res = ~(ua | ub);
      10: res = ua ^ ub;
      11: res = ~(ua ^ ub);
      12: begin res = ua << amt; c = (amt != 0) ? ((ua >> (8 - amt)) & 1) : 0; end
      13: begin res = ua >> amt; c = (amt != 0) ? ((ua >> (amt - 1)) & 1) : 0; end
      14: res = (ua << amt) | (ua >> (8 - amt));
      default: res = (ua >> amt) | (ua << (8 - amt));
    endcase
    r  = 8'(res);
    fl = {r == 8'h00, r[7], c != 0, v != 0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    sel = op; a = av; b = bv; in_valid = 1;
    cur_op = op; cur_a = av; cur_b = bv;
  endtask

  task automatic accept_wait(output int waited);
    exp_t it;
    logic got;
    got = 0;
    waited = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model(int'(cur_op), int'($signed(cur_a)), int'($signed(cur_b)), it.r, it.e, it.fl);
        it.acc = cyc;
        it.lat = (cur_op == 4'h3 || cur_op == 4'h4) ? 9 : 1;
        exp_q.push_back(it);
        got = 1;
        break;
      end
      step();
      waited++;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: op %0h never accepted", cur_op);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    int w;
    drive(op, av, bv);
    accept_wait(w);
    step();
    in_valid = 0;
  endtask

  // Monitor: latency on first presentation, stability while held, value at handshake.
  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_out: out=%0h with no pending op", out);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
          seen = 1;
        end else chk("hold_stable", {23'd0, out, err}, {23'd0, held});
        held = {out, err};
        if (out_ready) begin
          chk("result", {24'd0, out}, {24'd0, exp_q[0].r});
          chk("err", {31'd0, err}, {31'd0, exp_q[0].e});
`ifdef ALU_SEQ_FLAGS_EN
          chk("flags", {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, exp_q[0].fl});
`endif
          void'(exp_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    int w;
    logic [7:0] ra, rb;
    rst_n = 0; in_valid = 0; a = 0; b = 0; sel = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out", {24'd0, out}, 0);
    chk("rst_err", {31'd0, err}, 0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 1);
    step();

    issue(4'h3, 8'hF9, 8'h02);
    issue(4'h4, 8'hF9, 8'h02);
    issue(4'h3, 8'd25, 8'h00);
    issue(4'h4, 8'd25, 8'h00);
    issue(4'hE, 8'h81, 8'd1);
    issue(4'hF, 8'h81, 8'd3);
    issue(4'hC, 8'h81, 8'd8);
    issue(4'h3, 8'h80, 8'hFF);
    issue(4'h4, 8'h80, 8'hFF);
    issue(4'h0, 8'h7F, 8'h01);
    drive(4'hA, 8'hF0, 8'h0F);
    accept_wait(w);
    chk("b2b_accept_wait", 32'(w), 0);
    step();
    in_valid = 0;
    repeat (2) step();

    rdy_fixed = 0;
    issue(4'h1, 8'h10, 8'h20);
    out_ready = 0;
    drive(4'h6, 8'h0C, 8'h30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_out", {24'd0, out}, 32'hF0);
      step();
    end
    rdy_fixed = 1;
    out_ready = 1;
    accept_wait(w);
    chk("bp_same_cycle_accept", 32'(w), 0);
    step();
    in_valid = 0;
    repeat (2) step();

    issue(4'h3, 8'd100, 8'd7);
    repeat (3) step();
    rst_n = 0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_out_valid", {31'd0, out_valid}, 0);
    chk("abort_out", {24'd0, out}, 0);
    chk("abort_in_ready", {31'd0, in_ready}, 0);
    step();
    rst_n = 1;
    @(negedge clk);
    chk("abort_rel_in_ready", {31'd0, in_ready}, 1);
    repeat (12) step();
    issue(4'h3, 8'd100, 8'd7);
    issue(4'h4, 8'd100, 8'd7);

    rdy_rand = 1;
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 2)) step();
      case ($urandom_range(0, 7))
        0: ra = 8'h80;
        1: ra = 8'h7F;
        2: ra = 8'h00;
        default: ra = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: rb = 8'h00;
        1: rb = 8'hFF;
        2: rb = 8'h80;
        default: rb = 8'($urandom);
      endcase
      issue(4'($urandom_range(0, 15)), ra, rb);
    end

    rdy_rand = 0;
    rdy_fixed = 1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised signed ALU with valid/ready handshakes on input and result. It implements the team's 16-op ALU encoding at any width N. Shifts and rotates take a variable amount from B, and div/mod run on an iterative multi-cycle divider. Sits between an operand-issue stage and a result-writeback stage; one operation is in flight at a time.

Parameters:
N, 8, operand/result width in bits; power of two, 4..64
SW, $clog2(N), derived shift-amount width; not overridable

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and sel presented
in_ready  output  1  block can accept an operation this cycle
a  input  N  signed operand A
b  input  N  signed operand B; B[SW-1:0] is the shift/rotate amount
sel  input  4  opcode (encoding below)
out_valid  output  1  result and status valid
out_ready  input  1  consumer accepts result
out  output  N  signed result
err  output  1  division or modulo by zero on current result

Behaviour:
- Opcodes: 0 add, 1 sub, 2 mul (low N bits), 3 div, 4 mod, 5 and, 6 or, 7 not A, 8 nand, 9 nor, A xor, B xnor, C shl A by B[SW-1:0], D logical shr, E rotl, F rotr. Amount 0 -> out=A.
- Add/sub/mul wrap modulo 2^N.
- Accept: the cycle with in_valid && in_ready. a, b and sel are captured into internal registers; the inputs are don't-care afterwards.
- FSM: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On accept, sel 3/4 -> CALC; all other opcodes compute into the output register and go to DONE.
  - CALC: restoring division on operand magnitudes, one quotient bit per cycle, N cycles, then DONE. in_ready=0.
  - DONE: out_valid=1; out and err held stable until out_ready. out_valid && out_ready -> IDLE.
  - Also in DONE: in_ready=out_ready. A simultaneous accept loads the new operation, so there is no bubble for single-cycle ops.
- Latency, accept to out_valid: 1 cycle for non-div ops; N+1 cycles for div/mod.
- Div/mod semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
  - b=0: div gives out = all ones, mod gives out = a; err=1. Still takes N+1 cycles.
  - a=MIN, b=-1: div gives MIN, mod gives 0, err=0.
- err is 0 for all non-div/mod ops.
- Reset values: in_ready=0 while rst_n low, then 1 (IDLE); out_valid=0, out=0, err=0, FSM=IDLE, divider registers=0.
- Reset asserted mid-CALC or in DONE aborts the operation and discards the result; no out_valid follows.
- An undefined sel is impossible (4-bit, fully decoded).

Optional Feature:
ALU_SEQ_FLAGS_EN
- Defined: adds four output ports, all reset 0, registered and held with out, valid with out_valid.
  - flag_z: out==0.
  - flag_n: out[N-1].
  - flag_c: carry out of add; borrow (a<b unsigned) for sub; last bit shifted out for shl/shr; 0 otherwise.
  - flag_v: signed overflow for add, sub and mul (full product not representable in N bits); 0 otherwise.
- Undefined: ports absent, no flag logic.

Test Plan:
N=8, div a=-7 b=2, out_ready=1 -> out=0xFD (-3), out_valid exactly 9 cycles after accept; then mod a=-7 b=2 -> out=0xFF (-1), err=0.
div a=25 b=0 -> out=0xFF, err=1 after 9 cycles; mod a=25 b=0 -> out=0x19, err=1.
rotl a=0x81 b=1 -> 0x03; rotr a=0x81 b=3 -> 0x30; shl a=0x81 b=8 (amount 0) -> 0x81; all 1 cycle.
Back-to-back add 0x7F+0x01 then xor 0xF0^0x0F with out_ready=1 -> 0x80 then 0xFF on consecutive cycles. With ALU_SEQ_FLAGS_EN, first result flags v=1, n=1, c=0, z=0.
Backpressure: out_ready=0 for 5 cycles after sub 0x10-0x20 -> out=0xF0 held stable, in_ready=0, new in_valid not accepted; then out_ready=1 -> handshake completes, next op accepted the same cycle.
Deassert rst_n 4 cycles into div 100/7 -> out_valid=0, out=0, in_ready=0 during reset, 1 after release. New div 100/7 -> out=0x0E; mod 100/7 -> 0x02.
